// File: rtl/soc_system_pio_bidir_if.sv
// Avalon-MM lightweight slave bus bundle for soc_system_pio_bidir.
// The master drives address and strobes; the slave returns combinational readdata.
interface soc_system_pio_bidir_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_pio_bidir.sv
// Bidirectional PIO slave: per-bit direction, synchronised inputs, edge capture with IRQ.
// Optional atomic OUTSET/OUTCLR registers are built when PIO_OUTSETCLR_EN is defined.
module soc_system_pio_bidir #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] OUT_RESET = '0,
    parameter int unsigned      EDGE_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    soc_system_pio_bidir_if.slave bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic [WIDTH-1:0]     out_port,
    output logic [WIDTH-1:0]     oe,
    output logic                 irq
);

    typedef enum logic [2:0] {
        ADDR_DATA    = 3'd0,
        ADDR_DIR     = 3'd1,
        ADDR_MASK    = 3'd2,
        ADDR_CAPTURE = 3'd3,
        ADDR_OUTSET  = 3'd4,
        ADDR_OUTCLR  = 3'd5
    } reg_addr_e;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] capture_q, capture_d;
    logic [WIDTH-1:0] s1_q, s2_q, s3_q;
    logic [1:0]       warm_q, warm_d;

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_bits;
    logic [31:0]      rd_data;
    logic             unused_wd;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

    // Edge polarity is fixed at elaboration; s3 is the previous s2 sample.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        edge_raw = '0;
        case (EDGE_TYPE)
            0:       edge_raw = s2_q & ~s3_q;
            1:       edge_raw = ~s2_q & s3_q;
            default: edge_raw = s2_q ^ s3_q;
        endcase
        edge_det = (warm_q == 2'd3) ? edge_raw : '0;
    end

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        clr_bits   = '0;
        warm_d     = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        if (wr_en) begin
            case (reg_addr_e'(bus.address))
                ADDR_DATA:    data_out_d = wd;
                ADDR_DIR:     dir_d      = wd;
                ADDR_MASK:    mask_d     = wd;
                ADDR_CAPTURE: clr_bits   = wd;
`ifdef PIO_OUTSETCLR_EN
                ADDR_OUTSET:  data_out_d = data_out_q | wd;
                ADDR_OUTCLR:  data_out_d = data_out_q & ~wd;
`endif
                default: ;
            endcase
        end
        // A new edge in the same cycle as a clear keeps the bit set.
        capture_d = (capture_q & ~clr_bits) | edge_det;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            data_out_q <= OUT_RESET;
            dir_q      <= '0;
            mask_q     <= '0;
            capture_q  <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            warm_q     <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            capture_q  <= capture_d;
            s1_q       <= in_port;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            warm_q     <= warm_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_addr_e'(bus.address))
            ADDR_DATA:    rd_data[WIDTH-1:0] = (data_out_q & dir_q) | (s2_q & ~dir_q);
            ADDR_DIR:     rd_data[WIDTH-1:0] = dir_q;
            ADDR_MASK:    rd_data[WIDTH-1:0] = mask_q;
            ADDR_CAPTURE: rd_data[WIDTH-1:0] = capture_q;
            default:      rd_data = '0;
        endcase
    end

    assign bus.readdata = rd_data;
    assign out_port     = data_out_q;
    assign oe           = dir_q;
    assign irq          = |(capture_q & mask_q);

endmodule

// File: doc/soc_system_pio_bidir.md
# soc_system_pio_bidir

Parametrised bidirectional parallel I/O slave on the lightweight HPS-to-FPGA Avalon-MM bus. It is the next-generation general-purpose PIO: configurable width, per-bit direction, synchronised inputs, edge capture with maskable interrupt, and optional atomic set/clear of output bits. It drives board-level signals such as LEDs, motor enables and limit-switch inputs from software.

## Interface
- `WIDTH`, 8: number of I/O bits, 1..32.
- `OUT_RESET`, 0: reset value of the output data register, WIDTH bits.
- `EDGE_TYPE`, 0: edge that sets a capture bit. 0 = rising, 1 = falling, 2 = any.

- `clk`, in, 1: the single clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `address`, in, 3: word address of the register.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe.
- `writedata`, in, 32: write data.
- `readdata`, out, 32: read data. Combinational from `address`, zero wait states.
- `in_port`, in, WIDTH: asynchronous pin inputs.
- `out_port`, out, WIDTH: output data register.
- `oe`, out, WIDTH: per-bit output enable, 1 = output. Equals the direction register.
- `irq`, out, 1: level interrupt, `|(capture & mask)`.

## Operation
- A write occurs on a cycle with `chipselect` = 1 and `write_n` = 0.
- Only `writedata[WIDTH-1:0]` is used. `readdata` bits at WIDTH and above read 0.
- Address 0, DATA:
  - Write loads `data_out`, including bits currently configured as inputs.
  - Read bit i returns `data_out[i]` when `dir[i]` = 1, otherwise `in_sync[i]`.
- Address 1, DIR: read/write direction register.
- Address 2, MASK: read/write interrupt mask.
- Address 3, CAPTURE:
  - Read returns the edge-capture bits.
  - Write 1 clears a bit; write 0 leaves it unchanged.
- Address 4, OUTSET: write does `data_out |= wd`.
- Address 5, OUTCLR: write does `data_out &= ~wd`.
- Addresses 4 and 5 read 0. Addresses 6 and 7 read 0 and ignore writes.
- Input path:
  - `in_port` passes through a two-flop synchroniser, `s1` then `s2`, giving `in_sync` = `s2`.
  - A third register, `s3`, holds the previous value of `s2`.
  - The edge for bit i is evaluated from `s2` and `s3` according to EDGE_TYPE.
  - Edges are detected on all bits regardless of `dir`.
- Warm-up counter:
  - A 2-bit counter loads 0 on reset and saturates at 3.
  - Edge detection is suppressed while the counter is below 3.
  - This prevents a pin that is static through reset from setting a capture bit.
- Reset values:
  - `data_out` = OUT_RESET, so `out_port` = OUT_RESET.
  - `dir` = 0, so `oe` = 0.
  - `mask` = 0, `capture` = 0, `irq` = 0.
  - `s1`, `s2`, `s3` = 0 and warm-up counter = 0.
  - `readdata` follows the register contents.

## Timing
- Register writes take effect at the clock edge of the write cycle. `out_port`, `oe` and `irq` reflect the new value in the next cycle.
- Reads are combinational. `readdata` is valid in the same cycle as `address` and `chipselect`.
- Edge latency: a pin change first sampled by `s1` at edge k appears in `s2` at edge k+1. The capture bit sets at edge k+2, and `irq` rises after edge k+2 if the bit is masked in.
- A pulse on `in_port` shorter than one clock period may be missed.
- Simultaneous clear-write and new edge on the same bit: set wins and the bit stays 1.
- Simultaneous edge and a MASK write: `irq` uses the new mask from the next cycle.
- Reset asserted mid-operation restores all reset values at that edge. Captures pending at that edge are lost.

## Configuration
- Macro `PIO_OUTSETCLR_EN`.
- Defined: addresses 4 and 5 perform atomic set and clear of `data_out`.
- Undefined: the set/clear logic is not built. Writes to addresses 4 and 5 are ignored and those addresses read 0.
- All other behaviour is unchanged in both builds.

## Test plan
- Reset with OUT_RESET = 8'hA5 and `in_port` = 8'hFF held high:
  - `out_port` = A5, `oe` = 00 and `irq` = 0.
  - CAPTURE reads 00 after 10 cycles, so warm-up suppression works.
- Direction and DATA readback:
  - Write DIR = 8'h0F and DATA = 8'h3C with `in_port` = 8'hA0.
  - `oe` = 0F, `out_port` = 3C, and a DATA read 2 cycles later returns A0 | 0C = 8'hAC.
- Rising-edge interrupt, EDGE_TYPE = 0:
  - Write MASK = 8'h01 and raise `in_port[0]` before edge k.
  - CAPTURE = 01 after edge k+2 and `irq` = 1.
  - Write CAPTURE = 01, then `irq` = 0 the next cycle.
  - Falling `in_port[0]` leaves CAPTURE = 00.
- Clear/set collision: issue the CAPTURE write-1 on bit 0 in the same cycle a new edge on bit 0 is detected. Bit 0 reads 1.
- With `PIO_OUTSETCLR_EN`:
  - From DATA = 8'h0F, write OUTSET = 8'h30, then `out_port` = 3F.
  - Write OUTCLR = 8'h03, then `out_port` = 3C.
  - Without the macro, the same writes leave `out_port` = 0F.
- WIDTH = 32, EDGE_TYPE = 2:
  - Toggling `in_port[31]` both ways sets CAPTURE[31] each time.
  - Address 7 reads 0.
